// File: rtl/zbt_port_arbiter.sv
// Three-way arbiter for a single pipelined ZBT SRAM port. It issues one access per cycle.
// Write data is delayed to the data slot, and read data is steered back to its owner by tag.
module zbt_port_arbiter #(
  parameter int AW      = 19,
  parameter int DW      = 36,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          disp_req,
  input  logic          disp_we,
  input  logic [AW-1:0] disp_addr,
  input  logic [DW-1:0] disp_wdata,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  input  logic          cam_req,
  input  logic          cam_we,
  input  logic [AW-1:0] cam_addr,
  input  logic [DW-1:0] cam_wdata,
  output logic          cam_gnt,
  output logic          cam_rvalid,
  input  logic          proc_req,
  input  logic          proc_we,
  input  logic [AW-1:0] proc_addr,
  input  logic [DW-1:0] proc_wdata,
  output logic          proc_gnt,
  output logic          proc_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wdata_en,
  input  logic [DW-1:0] mem_rdata
);

  typedef struct packed {
    logic [1:0] owner;
    logic       we;
  } tag_t;

  localparam logic [1:0] OWN_DISP = 2'd0;
  localparam logic [1:0] OWN_CAM  = 2'd1;
  localparam logic [1:0] OWN_PROC = 2'd2;

  logic                        rr_proc;   // 0: cam favoured, 1: proc favoured
  logic [MEM_LAT:0]            vld_pipe;
  tag_t [MEM_LAT:0]            tag_pipe;
  logic [MEM_LAT:0][DW-1:0]    wd_pipe;

  logic          accept;
  tag_t          acc_tag;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          rd_slot;

  // disp always wins; cam/proc contend through the round-robin pointer
  always_comb begin
    disp_gnt = reset & disp_req;
    cam_gnt  = reset & ~disp_req & cam_req  & (~proc_req | ~rr_proc);
    proc_gnt = reset & ~disp_req & proc_req & (~cam_req  |  rr_proc);
  end

  always_comb begin
    accept    = disp_gnt | cam_gnt | proc_gnt;
    acc_tag   = '{owner: OWN_DISP, we: disp_we};
    acc_addr  = disp_addr;
    acc_wdata = disp_wdata;
    if (cam_gnt) begin
      acc_tag   = '{owner: OWN_CAM, we: cam_we};
      acc_addr  = cam_addr;
      acc_wdata = cam_wdata;
    end else if (proc_gnt) begin
      acc_tag   = '{owner: OWN_PROC, we: proc_we};
      acc_addr  = proc_addr;
      acc_wdata = proc_wdata;
    end
  end

  assign rd_slot      = vld_pipe[MEM_LAT] & ~tag_pipe[MEM_LAT].we;
  assign mem_wdata_en = vld_pipe[MEM_LAT] &  tag_pipe[MEM_LAT].we;
  assign mem_wdata    = wd_pipe[MEM_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_proc     <= 1'b0;
      vld_pipe    <= '0;
      tag_pipe    <= '0;
      wd_pipe     <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      rdata       <= '0;
      disp_rvalid <= 1'b0;
      cam_rvalid  <= 1'b0;
      proc_rvalid <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[MEM_LAT-1:0], accept};
      tag_pipe <= {tag_pipe[MEM_LAT-1:0], acc_tag};
      wd_pipe  <= {wd_pipe[MEM_LAT-1:0], (accept & acc_tag.we) ? acc_wdata : {DW{1'b0}}};
      mem_we   <= accept & acc_tag.we;
      if (accept)
        mem_addr <= acc_addr;
      if (cam_gnt)
        rr_proc <= 1'b1;
      else if (proc_gnt)
        rr_proc <= 1'b0;
      // data at the bus this cycle belongs to the access issued MEM_LAT cycles ago
      if (rd_slot)
        rdata <= mem_rdata;
      disp_rvalid <= rd_slot & (tag_pipe[MEM_LAT].owner == OWN_DISP);
      cam_rvalid  <= rd_slot & (tag_pipe[MEM_LAT].owner == OWN_CAM);
      proc_rvalid <= rd_slot & (tag_pipe[MEM_LAT].owner == OWN_PROC);
    end
  end

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// Bench for zbt_port_arbiter. A cycle-slot scoreboard with a sequential memory model
// and a two-cycle ZBT model checks arbitration, address, write data and read return.
module tb_zbt_port_arbiter;
  localparam int AW = 19;
  localparam int DW = 36;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0]    req;
  logic [2:0]    we;
  logic [AW-1:0] addr  [3];
  logic [DW-1:0] wdata [3];
  logic disp_gnt, cam_gnt, proc_gnt, disp_rvalid, cam_rvalid, proc_rvalid;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_we, mem_wdata_en;
  logic [2:0] gnt, rv;

  assign gnt = {proc_gnt, cam_gnt, disp_gnt};
  assign rv  = {proc_rvalid, cam_rvalid, disp_rvalid};

  zbt_port_arbiter dut (
    .clk(clk), .reset(reset),
    .disp_req(req[0]), .disp_we(we[0]), .disp_addr(addr[0]), .disp_wdata(wdata[0]),
    .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid),
    .cam_req(req[1]), .cam_we(we[1]), .cam_addr(addr[1]), .cam_wdata(wdata[1]),
    .cam_gnt(cam_gnt), .cam_rvalid(cam_rvalid),
    .proc_req(req[2]), .proc_we(we[2]), .proc_addr(addr[2]), .proc_wdata(wdata[2]),
    .proc_gnt(proc_gnt), .proc_rvalid(proc_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_wdata_en(mem_wdata_en), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 19'd3) return 36'h0_1F40_0000;
    return {4'h9, a[15:0], ~a[15:0]};
  endfunction

  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] zmem    [int];

  function automatic logic [DW-1:0] ref_get(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] zget(input logic [AW-1:0] a);
    return zmem.exists(int'(a)) ? zmem[int'(a)] : init_val(a);
  endfunction

  // Expected per-cycle memory-side and return-side events, ring-indexed by cycle
  typedef struct {
    bit          acc;
    bit          we;
    bit [AW-1:0] addr;
    bit          wen;
    bit [DW-1:0] wdata;
    bit [2:0]    rv;
    bit [DW-1:0] rd;
  } slot_t;

  slot_t slots [8];
  slot_t blank;
  slot_t msl;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_rd;
  int fav;          // requester favoured when cam and proc both ask: 1 cam, 2 proc
  int mw, mold, ms;
  bit          zq_we   [4];
  bit [AW-1:0] zq_addr [4];

  always @(negedge clk) begin
    ms = cyc % 8;
    if (!reset) begin
      chk("reset_state", {gnt, rv, mem_we, mem_wdata_en, |mem_addr, |mem_wdata, |rdata}, 64'd0);
      for (int i = 0; i < 8; i++) slots[i] = blank;
      for (int i = 0; i < 4; i++) zq_we[i] = 1'b1;
      fav = 1;
      last_addr = '0;
      last_rd = '0;
      mem_rdata = '0;
    end else begin
      msl = slots[ms];
      slots[ms] = blank;
      if (msl.acc) last_addr = msl.addr;
      chk("mem_we", mem_we, msl.we);
      chk("mem_addr", mem_addr, last_addr);
      chk("wdata_en", mem_wdata_en, msl.wen);
      if (msl.wen) chk("mem_wdata", mem_wdata, msl.wdata);
      chk("rvalid", rv, msl.rv);
      if (msl.rv != 0) last_rd = msl.rd;
      chk("rdata", rdata, last_rd);

      mw = -1;
      if (req[0]) mw = 0;
      else if (req[1] && req[2]) mw = fav;
      else if (req[1]) mw = 1;
      else if (req[2]) mw = 2;
      chk("gnt", gnt, (mw < 0) ? 3'b000 : 3'(1 << mw));
      if (mw >= 0) begin
        if (mw != 0) fav = 3 - mw;
        slots[(cyc+1)%8].acc  = 1'b1;
        slots[(cyc+1)%8].addr = addr[mw];
        slots[(cyc+1)%8].we   = we[mw];
        if (we[mw]) begin
          slots[(cyc+3)%8].wen   = 1'b1;
          slots[(cyc+3)%8].wdata = wdata[mw];
          ref_mem[int'(addr[mw])] = wdata[mw];
        end else begin
          slots[(cyc+4)%8].rv = 3'(1 << mw);
          slots[(cyc+4)%8].rd = ref_get(addr[mw]);
        end
      end

      // ZBT: address this cycle, data two cycles later
      zq_we[cyc%4]   = mem_we;
      zq_addr[cyc%4] = mem_addr;
      mold = (cyc + 2) % 4;
      if (mem_wdata_en) zmem[int'(zq_addr[mold])] = mem_wdata;
      mem_rdata = zq_we[mold] ? {4'($urandom), 32'($urandom)} : zget(zq_addr[mold]);
    end
  end

  typedef struct {
    logic [2:0] req;
    logic [2:0] gnt;
  } vec_t;
  vec_t tbl [12];

  logic [2:0] g, pg;
  int cc, pc, cnt;

  initial begin
    req = 3'b111;
    we = '0;
    for (int i = 0; i < 3; i++) begin addr[i] = '0; wdata[i] = '0; end
    mem_rdata = '0;
    // bit0 disp, bit1 cam, bit2 proc; pointer starts on cam
    tbl[0]  = '{3'b000, 3'b000};
    tbl[1]  = '{3'b111, 3'b001};
    tbl[2]  = '{3'b110, 3'b010};
    tbl[3]  = '{3'b110, 3'b100};
    tbl[4]  = '{3'b100, 3'b100};
    tbl[5]  = '{3'b110, 3'b010};
    tbl[6]  = '{3'b010, 3'b010};
    tbl[7]  = '{3'b100, 3'b100};
    tbl[8]  = '{3'b101, 3'b001};
    tbl[9]  = '{3'b110, 3'b010};
    tbl[10] = '{3'b011, 3'b001};
    tbl[11] = '{3'b110, 3'b100};

    repeat (3) @(posedge clk);
    #1 req = '0; reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      req = tbl[i].req;
      we = '0;
      for (int x = 0; x < 3; x++) addr[x] = AW'(64 + i * 3 + x);
      @(negedge clk);
      chk("tbl_gnt", gnt, tbl[i].gnt);
    end
    @(posedge clk); #1 req = '0;
    repeat (5) @(posedge clk);

    // 1: proc read of addr 3
    #1 req[2] = 1'b1; we[2] = 1'b0; addr[2] = 19'd3;
    @(negedge clk); chk("t1_gnt", gnt, 3'b100);
    @(posedge clk); #1 req[2] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t1_rv", rv, (k == 4) ? 3'b100 : 3'b000);
    end
    chk("t1_rdata", rdata, 36'h0_1F40_0000);

    // 2: disp and proc together
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 19'd20;
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 19'd21;
    @(negedge clk); chk("t2_first", gnt, 3'b001);
    @(posedge clk); #1 req[0] = 1'b0;
    @(negedge clk); chk("t2_second", gnt, 3'b100);
    @(posedge clk); #1 req[2] = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk("t2_rv", rv, (k == 4) ? 3'b001 : (k == 5) ? 3'b100 : 3'b000);
      if (k == 4) chk("t2_rdata_disp", rdata, init_val(19'd20));
      if (k == 5) chk("t2_rdata_proc", rdata, init_val(19'd21));
    end

    // 3: cam and proc saturating for 10 cycles
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 19'd30;
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 19'd31;
    cc = 0; pc = 0; pg = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      g = gnt;
      chk("t3_one_gnt", (g == 3'b010) || (g == 3'b100), 1'b1);
      if (k > 0) chk("t3_alternate", g != pg, 1'b1);
      if (g[1]) cc++;
      if (g[2]) pc++;
      pg = g;
    end
    chk("t3_counts", {cc[7:0], pc[7:0]}, {8'd5, 8'd5});
    @(posedge clk); #1 req = '0;
    repeat (5) @(posedge clk);

    // 4: cam write
    #1 req[1] = 1'b1; we[1] = 1'b1; addr[1] = 19'd1027; wdata[1] = 36'hABC;
    @(negedge clk); chk("t4_gnt", gnt, 3'b010);
    @(posedge clk); #1 req[1] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) chk("t4_addr", {mem_we, mem_addr}, {1'b1, 19'd1027});
      chk("t4_wen", mem_wdata_en, k == 3);
      if (k == 3) chk("t4_wdata", mem_wdata, 36'hABC);
      chk("t4_rv", rv, 3'b000);
    end

    // 5: proc read 4, write 5, read 2051 back to back
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 19'd4;
    @(negedge clk); chk("t5_gnt0", gnt, 3'b100);
    @(posedge clk); #1 we[2] = 1'b1; addr[2] = 19'd5; wdata[2] = 36'h5_0000_0005;
    @(negedge clk); chk("t5_gnt1", gnt, 3'b100); chk("t5_addr4", mem_addr, 19'd4);
    @(posedge clk); #1 we[2] = 1'b0; addr[2] = 19'd2051;
    @(negedge clk); chk("t5_gnt2", gnt, 3'b100); chk("t5_addr5", {mem_we, mem_addr}, {1'b1, 19'd5});
    @(posedge clk); #1 req[2] = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) chk("t5_addr2051", mem_addr, 19'd2051);
      chk("t5_wen", mem_wdata_en, k == 4);
      chk("t5_rv", rv, (k == 4 || k == 6) ? 3'b100 : 3'b000);
      if (k == 4) chk("t5_rd4", rdata, init_val(19'd4));
      if (k == 6) chk("t5_rd2051", rdata, init_val(19'd2051));
    end

    // 6: reset one cycle after a disp read is accepted
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 19'd9;
    @(negedge clk); chk("t6_gnt", gnt, 3'b001);
    @(posedge clk); #1 req[0] = 1'b0;
    chk("t6_pre", mem_addr, 19'd9);
    #2 reset = 1'b0;
    #1 chk("t6_async", {gnt, rv, mem_we, mem_wdata_en, |mem_addr, |rdata, |mem_wdata}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (disp_rvalid) cnt++;
    end
    chk("t6_no_rv", cnt, 0);

    // randomized traffic, small address window so reads hit earlier writes
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk); #1;
      for (int x = 0; x < 3; x++) begin
        if (req[x] && g[x]) req[x] = 1'b0;
        else if (req[x] && $urandom_range(7) == 0) req[x] = 1'b0;
        if (!req[x] && $urandom_range((x == 0) ? 3 : 1) == 0) begin
          req[x]   = 1'b1;
          we[x]    = 1'($urandom_range(1));
          addr[x]  = AW'($urandom_range(15));
          wdata[x] = {4'($urandom), 32'($urandom)};
        end
      end
    end
    @(posedge clk); #1 req = '0;
    repeat (8) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
